// File: rtl/geo_pkg.sv
// ---------------------------------------------------------------------------
// geo_pkg
// Shared definitions for the geofence datapath blocks.
//   geo_state_e : state encoding of the shared square-root scheduler
//   RAD_W_DEF   : default radicand width used by the square-root path
//   geo_clog2   : ceil(log2(value)), never smaller than 1, for sizing
//                 id fields, pointers and iteration counters
// ---------------------------------------------------------------------------
package geo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } geo_state_e;

   localparam int RAD_W_DEF = 24;

   // A zero-width field is never useful here, so the result is at least 1.
   function automatic int geo_clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/geo_sqrt_iter.sv
// ---------------------------------------------------------------------------
// geo_sqrt_iter
// Iterative restoring square-root engine, one root bit per clock.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high; clears the engine
//   start  in  load rad and clear all iteration state (one-cycle pulse)
//   rad    in  RAD_W-bit unsigned radicand, sampled when start is high
//   done   out high during the final iteration cycle
//   root   out RAD_W/2-bit floor(sqrt(rad)); complete the cycle after done
// ---------------------------------------------------------------------------
module geo_sqrt_iter
   import geo_pkg::*;
#(
   parameter int RAD_W = RAD_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [RAD_W-1:0]   rad,
   output logic               done,
   output logic [RAD_W/2-1:0] root
);

   localparam int HALF  = RAD_W / 2;
   localparam int REM_W = HALF + 2;
   localparam int CNT_W = geo_clog2(HALF);

   logic [RAD_W-1:0] rad_q,    rad_d;
   logic [REM_W-1:0] rem_q,    rem_d;
   logic [HALF-1:0]  root_q,   root_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             active_q, active_d;

   logic [REM_W+1:0] rem_shift;
   logic [REM_W+1:0] trial;
   logic [REM_W+1:0] diff;

   // Engine registers. Everything is cleared on reset so an aborted
   // operation leaves nothing behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         rad_q    <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         rad_q    <= rad_d;
         rem_q    <= rem_d;
         root_q   <= root_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   // One restoring step per cycle: bring down the next two radicand bits,
   // try subtracting (4*root + 1), keep the difference and emit a 1 if it
   // did not go negative, otherwise keep the shifted remainder and emit 0.
   // The shift and trial are widened by two bits so every remainder bit
   // takes part and the compare can never wrap.
   always_comb begin
      rad_d     = rad_q;
      rem_d     = rem_q;
      root_d    = root_q;
      cnt_d     = cnt_q;
      active_d  = active_q;
      done      = 1'b0;
      rem_shift = {rem_q, rad_q[RAD_W-1 -: 2]};
      trial     = {2'b00, root_q, 2'b01};
      diff      = rem_shift - trial;

      if (start) begin
         rad_d    = rad;
         rem_d    = '0;
         root_d   = '0;
         cnt_d    = '0;
         active_d = 1'b1;
      end else if (active_q) begin
         rad_d = rad_q << 2;
         if (rem_shift >= trial) begin
            rem_d  = REM_W'(diff);
            root_d = HALF'({root_q, 1'b1});
         end else begin
            rem_d  = REM_W'(rem_shift);
            root_d = HALF'({root_q, 1'b0});
         end
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(HALF - 1)) begin
            done     = 1'b1;
            active_d = 1'b0;
         end
      end
   end

   assign root = root_q;

endmodule

// File: rtl/geo_sqrt_sched.sv
// ---------------------------------------------------------------------------
// geo_sqrt_sched
// Round-robin scheduler sharing one iterative square-root engine between
// N requesters of the geofence datapath.
// Ports:
//   clk        in  rising-edge clock
//   reset      in  synchronous, active-high
//   req_valid  in  [N]       per-requester request, held until accepted
//   req_rad    in  [N*RAD_W] packed radicands, requester i at [i*RAD_W +: RAD_W]
//   req_ready  out [N]       one-hot combinational accept, IDLE only
//   resp_valid out [N]       one-hot single-cycle result strobe
//   resp_root  out [RAD_W/2] floor(sqrt(radicand)), held until next result
//   resp_id    out [IDW]     requester owning the current result, held
//   busy       out           high while an operation is in CALC or DONE
// ---------------------------------------------------------------------------
module geo_sqrt_sched
   import geo_pkg::*;
#(
   parameter int N     = 2,
   parameter int RAD_W = RAD_W_DEF,
   parameter int IDW   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       req_valid,
   input  logic [N*RAD_W-1:0] req_rad,
   output logic [N-1:0]       req_ready,
   output logic [N-1:0]       resp_valid,
   output logic [RAD_W/2-1:0] resp_root,
   output logic [IDW-1:0]     resp_id,
   output logic               busy
);

   localparam int HALF  = RAD_W / 2;
   localparam int PTR_W = geo_clog2(N);

   // Reject parameter sets the datapath cannot support.
   if (RAD_W % 2 != 0) begin : g_chk_rad_even
      $error("geo_sqrt_sched: RAD_W must be even");
   end
   if (N < 2 || N > 8) begin : g_chk_n_range
      $error("geo_sqrt_sched: N must be in 2..8");
   end
   if ((1 << IDW) < N) begin : g_chk_idw
      $error("geo_sqrt_sched: IDW too narrow for N requesters");
   end

   geo_state_e       state_q, state_d;
   logic [PTR_W-1:0] ptr_q,   ptr_d;
   logic [PTR_W-1:0] id_q,    id_d;
   logic [PTR_W-1:0] rid_q,   rid_d;
   logic [HALF-1:0]  res_q,   res_d;

   logic             grant_found;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W:0]   cand;
   logic [RAD_W-1:0] grant_rad;

   logic             start;
   logic             iter_done;
   logic [HALF-1:0]  iter_root;

   // Scheduler registers. The pointer resets to N-1 so that requester 0
   // is the first one searched after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= PTR_W'(N - 1);
         id_q    <= '0;
         rid_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         rid_q   <= rid_d;
         res_q   <= res_d;
      end
   end

   // Round-robin search: walk ptr+1, ptr+2, ... wrapping at N and take the
   // first requester that is asking. The candidate is one bit wider than
   // the pointer so ptr+k never overflows before the wrap subtraction.
   // The winner's radicand is also selected here for the engine load.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      grant_rad   = '0;
      for (int k = 1; k <= N; k++) begin
         cand = {1'b0, ptr_q} + (PTR_W + 1)'(k);
         if (cand >= (PTR_W + 1)'(N)) begin
            cand = cand - (PTR_W + 1)'(N);
         end
         for (int j = 0; j < N; j++) begin
            if (!grant_found && cand == (PTR_W + 1)'(j) && req_valid[j]) begin
               grant_found = 1'b1;
               grant_idx   = PTR_W'(j);
            end
         end
      end
      for (int j = 0; j < N; j++) begin
         if (grant_idx == PTR_W'(j)) begin
            grant_rad = req_rad[j*RAD_W +: RAD_W];
         end
      end
   end

   // FSM next state and outputs. Accepts only happen in IDLE; DONE raises
   // the owner's strobe for one cycle and latches the result so resp_root
   // and resp_id keep showing it until the following DONE.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      rid_d      = rid_q;
      res_d      = res_q;
      start      = 1'b0;
      req_ready  = '0;
      resp_valid = '0;
      busy       = 1'b0;
      resp_root  = res_q;
      resp_id    = IDW'(rid_q);

      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               start   = 1'b1;
               ptr_d   = grant_idx;
               id_d    = grant_idx;
               state_d = ST_CALC;
               for (int j = 0; j < N; j++) begin
                  req_ready[j] = (grant_idx == PTR_W'(j));
               end
            end
         end
         ST_CALC: begin
            busy = 1'b1;
            if (iter_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy      = 1'b1;
            resp_root = iter_root;
            resp_id   = IDW'(id_q);
            res_d     = iter_root;
            rid_d     = id_q;
            state_d   = ST_IDLE;
            for (int j = 0; j < N; j++) begin
               resp_valid[j] = (id_q == PTR_W'(j));
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   geo_sqrt_iter #(
      .RAD_W (RAD_W)
   ) u_iter (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .rad   (grant_rad),
      .done  (iter_done),
      .root  (iter_root)
   );

endmodule

// File: tb/tb_geo_sqrt_sched.sv
// ---------------------------------------------------------------------------
// tb_geo_sqrt_sched
// Self-checking bench for geo_sqrt_sched with N=2, RAD_W=24, IDW=3.
// A transaction-level model (round-robin pick from the last winner, fixed
// 13-cycle result latency, 14-cycle occupancy, floor(sqrt) by real math)
// is compared against the DUT every cycle, alongside directed vectors with
// hand-computed roots.
// ---------------------------------------------------------------------------
module tb_geo_sqrt_sched;

   localparam int N     = 2;
   localparam int RAD_W = 24;
   localparam int IDW   = 3;
   localparam int HALF  = RAD_W / 2;
   localparam int IW    = 1;

   logic               clk;
   logic               reset;
   logic [N-1:0]       req_valid;
   logic [N*RAD_W-1:0] req_rad;
   logic [N-1:0]       req_ready;
   logic [N-1:0]       resp_valid;
   logic [HALF-1:0]    resp_root;
   logic [IDW-1:0]     resp_id;
   logic               busy;

   logic [RAD_W-1:0]   rad_arr [N];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int id;
      int root;
      int due;
   } exp_t;

   exp_t         m_q[$];
   bit           m_en = 1'b0;
   int           m_idle_from = 0;
   int           m_last = N - 1;
   int           m_root_hold = 0;
   int           m_id_hold = 0;
   int           wait_start [N];
   bit           waiting [N];
   logic [N-1:0] acc_flag = '0;
   int           dut_resp_count = 0;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_rad[g*RAD_W +: RAD_W] = rad_arr[g];
   end

   geo_sqrt_sched #(
      .N     (N),
      .RAD_W (RAD_W),
      .IDW   (IDW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_rad    (req_rad),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_root  (resp_root),
      .resp_id    (resp_id),
      .busy       (busy)
   );

   // Free-running clock and cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Hard stop in case something hangs despite the bounded loops
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference floor(sqrt) from real arithmetic, nudged to the exact integer
   function automatic int isqrt(input longint v);
      longint r;
      r = longint'($floor($sqrt(real'(v))));
      while (r * r > v) r--;
      while ((r + 1) * (r + 1) <= v) r++;
      return int'(r);
   endfunction

   function automatic logic [N-1:0] onehotOf(input int id);
      logic [N-1:0] v;
      v = '0;
      v[IW'(id)] = 1'b1;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Advance one cycle, then release any request the model says was accepted
   task automatic stepCycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_flag[IW'(i)]) req_valid[IW'(i)] = 1'b0;
      end
   endtask

   task automatic applyStimulus(input int id, input logic [RAD_W-1:0] rad);
      req_valid[IW'(id)] = 1'b1;
      rad_arr[IW'(id)]   = rad;
   endtask

   task automatic doReset();
      stepCycle();
      reset     = 1'b1;
      req_valid = '0;
      repeat (2) stepCycle();
      reset = 1'b0;
   endtask

   // From an accept cycle, land on the result cycle and check it literally
   task automatic waitResult(input string name, input logic [N-1:0] exp_valid,
                             input int exp_root, input int exp_id);
      for (int t = 0; t < 13; t++) stepCycle();
      @(negedge clk);
      checkOutput({name, "_valid"}, 32'(resp_valid), 32'(exp_valid));
      checkOutput({name, "_root"},  32'(resp_root),  32'(exp_root));
      checkOutput({name, "_id"},    32'(resp_id),    32'(exp_id));
   endtask

   task automatic runSingle(input string name, input int id,
                            input logic [RAD_W-1:0] rad, input int exp_root);
      stepCycle();
      applyStimulus(id, rad);
      @(negedge clk);
      checkOutput({name, "_ready"}, 32'(req_ready), 32'(onehotOf(id)));
      waitResult(name, onehotOf(id), exp_root, id);
   endtask

   // Per-cycle comparison against the transaction model
   initial begin
      logic [N-1:0] exp_ready;
      logic [N-1:0] exp_valid;
      logic         exp_busy;
      int           g;
      int           cand;
      exp_t         e;
      forever begin
         @(negedge clk);
         if (reset) begin
            m_en        = 1'b1;
            m_idle_from = cyc + 1;
            m_last      = N - 1;
            m_q.delete();
            m_root_hold = 0;
            m_id_hold   = 0;
            acc_flag    = '0;
            for (int i = 0; i < N; i++) waiting[IW'(i)] = 1'b0;
         end else if (m_en) begin
            for (int i = 0; i < N; i++) begin
               if (req_valid[IW'(i)]) begin
                  if (!waiting[IW'(i)]) begin
                     waiting[IW'(i)]    = 1'b1;
                     wait_start[IW'(i)] = cyc;
                  end
               end else begin
                  waiting[IW'(i)] = 1'b0;
               end
            end
            exp_busy  = (cyc < m_idle_from);
            exp_ready = '0;
            exp_valid = '0;
            if (!exp_busy && req_valid != '0) begin
               g = -1;
               for (int k = 1; k <= N; k++) begin
                  cand = (m_last + k) % N;
                  if (g < 0 && req_valid[IW'(cand)]) g = cand;
               end
               exp_ready[IW'(g)] = 1'b1;
               e.id   = g;
               e.root = isqrt(longint'(rad_arr[IW'(g)]));
               e.due  = cyc + 13;
               m_q.push_back(e);
               m_last      = g;
               m_idle_from = cyc + 14;
               checkOutput("rr_wait_bound", 32'((cyc - wait_start[IW'(g)]) <= N * 14), 32'd1);
               waiting[IW'(g)] = 1'b0;
            end
            if (m_q.size() > 0 && m_q[0].due == cyc) begin
               exp_valid[IW'(m_q[0].id)] = 1'b1;
               m_root_hold = m_q[0].root;
               m_id_hold   = m_q[0].id;
               void'(m_q.pop_front());
            end
            if (resp_valid != '0) dut_resp_count++;
            checkOutput("model_req_ready",  32'(req_ready),  32'(exp_ready));
            checkOutput("model_resp_valid", 32'(resp_valid), 32'(exp_valid));
            checkOutput("model_busy",       32'(busy),       32'(exp_busy));
            checkOutput("model_resp_root",  32'(resp_root),  32'(m_root_hold));
            checkOutput("model_resp_id",    32'(resp_id),    32'(m_id_hold));
            acc_flag = exp_ready;
         end
      end
   end

   // Directed sequences followed by a random soak
   initial begin
      bit seen0;
      bit seen1;
      int issued;
      int budget;
      int resp_base;
      logic [RAD_W-1:0] r;

      reset     = 1'b1;
      req_valid = '0;
      for (int i = 0; i < N; i++) rad_arr[IW'(i)] = '0;
      repeat (3) stepCycle();
      reset = 1'b0;

      checkOutput("pin_isqrt_1e6",  32'(isqrt(64'd1000000)),  32'd1000);
      checkOutput("pin_isqrt_0",    32'(isqrt(64'd0)),        32'd0);
      checkOutput("pin_isqrt_max",  32'(isqrt(64'd16777215)), 32'd4095);
      checkOutput("pin_isqrt_99",   32'(isqrt(64'd99)),       32'd9);
      checkOutput("pin_isqrt_100",  32'(isqrt(64'd100)),      32'd10);

      @(negedge clk);
      checkOutput("reset_req_ready",  32'(req_ready),  32'd0);
      checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset_resp_root",  32'(resp_root),  32'd0);
      checkOutput("reset_resp_id",    32'(resp_id),    32'd0);
      checkOutput("reset_busy",       32'(busy),       32'd0);

      runSingle("single_1e6", 0, 24'd1000000, 1000);
      runSingle("bound_zero", 0, 24'd0,        0);
      runSingle("bound_max",  1, 24'd16777215, 4095);
      runSingle("bound_99",   0, 24'd99,       9);
      runSingle("bound_100",  1, 24'd100,      10);

      // Requester 1 shows up mid-operation and gives up before IDLE
      stepCycle();
      applyStimulus(0, 24'd400);
      repeat (3) stepCycle();
      applyStimulus(1, 24'd777);
      repeat (4) stepCycle();
      req_valid[1] = 1'b0;
      seen0 = 1'b0;
      seen1 = 1'b0;
      for (int t = 0; t < 16; t++) begin
         stepCycle();
         @(negedge clk);
         if (resp_valid[0]) seen0 = 1'b1;
         if (resp_valid[1]) seen1 = 1'b1;
      end
      checkOutput("withdraw_resp0_seen", 32'(seen0),     32'd1);
      checkOutput("withdraw_no_resp1",   32'(seen1),     32'd0);
      checkOutput("withdraw_idle_busy",  32'(busy),      32'd0);
      checkOutput("withdraw_idle_ready", 32'(req_ready), 32'd0);
      checkOutput("withdraw_root_held",  32'(resp_root), 32'd20);

      // Abort in the sixth CALC cycle, then contend from a fresh pointer
      stepCycle();
      applyStimulus(0, 24'd12345);
      repeat (6) stepCycle();
      reset     = 1'b1;
      req_valid = '0;
      stepCycle();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_req_ready",  32'(req_ready),  32'd0);
      checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("abort_resp_root",  32'(resp_root),  32'd0);
      checkOutput("abort_resp_id",    32'(resp_id),    32'd0);
      checkOutput("abort_busy",       32'(busy),       32'd0);
      stepCycle();
      applyStimulus(0, 24'd12345);
      applyStimulus(1, 24'd4);
      @(negedge clk);
      checkOutput("abort_first_ready", 32'(req_ready), 32'd1);
      waitResult("abort_r0", 2'b01, 111, 0);
      stepCycle();
      @(negedge clk);
      checkOutput("abort_second_ready", 32'(req_ready), 32'd2);
      waitResult("abort_r1", 2'b10, 2, 1);

      // Simultaneous requests from reset, twice in a row
      doReset();
      applyStimulus(0, 24'd2500);
      applyStimulus(1, 24'd81);
      @(negedge clk);
      checkOutput("cont_a_ready0", 32'(req_ready), 32'd1);
      waitResult("cont_a_r0", 2'b01, 50, 0);
      stepCycle();
      @(negedge clk);
      checkOutput("cont_a_ready1", 32'(req_ready), 32'd2);
      waitResult("cont_a_r1", 2'b10, 9, 1);
      stepCycle();
      applyStimulus(0, 24'd144);
      applyStimulus(1, 24'd169);
      @(negedge clk);
      checkOutput("cont_b_ready0", 32'(req_ready), 32'd1);
      waitResult("cont_b_r0", 2'b01, 12, 0);
      stepCycle();
      @(negedge clk);
      checkOutput("cont_b_ready1", 32'(req_ready), 32'd2);
      waitResult("cont_b_r1", 2'b10, 13, 1);

      // Random soak; the per-cycle model checks every result and wait time
      resp_base = dut_resp_count;
      issued    = 0;
      budget    = 0;
      while ((issued < 1000 || req_valid != '0) && budget < 40000) begin
         stepCycle();
         for (int i = 0; i < N; i++) begin
            if (!req_valid[IW'(i)] && issued < 1000 && $urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 7))
                  0:       r = '0;
                  1:       r = '1;
                  default: r = RAD_W'($urandom);
               endcase
               applyStimulus(i, r);
               issued++;
            end
         end
         budget++;
      end
      repeat (20) stepCycle();
      @(negedge clk);
      checkOutput("soak_in_budget",   32'(budget < 40000),               32'd1);
      checkOutput("soak_resp_count",  32'(dut_resp_count - resp_base),   32'd1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/geo_sqrt_sched.md
Name: geo_sqrt_sched

Overview:
- Round-robin scheduler that shares one iterative integer square-root engine between N requesters in the geofence datapath.
- Typical requesters are the triangle side-length path (sqrt of dx²+dy²) and the Heron-area path (sqrt of products).
- Replaces per-path combinational square-root instances with a single multi-cycle resource.
- Owns arbitration, operand capture, iteration sequencing and result routing.

Parameters:
- N, 2, number of requesters (2..8).
- RAD_W, 24, radicand width in bits. Must be even; odd values are illegal and are caught by an elaboration check.
- IDW, 3, width of resp_id. Must satisfy 2^IDW >= N.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  N  per-requester request; held until accepted
- req_rad  in  N*RAD_W  packed radicands; requester i uses bits [i*RAD_W +: RAD_W]
- req_ready  out  N  one-hot accept pulse, combinational, asserted in IDLE only
- resp_valid  out  N  one-hot, one-cycle result strobe
- resp_root  out  RAD_W/2  floor(sqrt(radicand)), unsigned
- resp_id  out  IDW  index of the requester owning the current result
- busy  out  1  high in CALC and DONE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: req_ready=0, resp_valid=0, resp_root=0, resp_id=0, busy=0, state=IDLE, priority pointer ptr=N-1, so requester 0 wins first.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - grant = first i with req_valid[i]=1, searching ptr+1, ptr+2, … modulo N.
  - req_ready[grant]=1 in the same cycle.
  - At the clock edge: capture req_rad[grant] and the grant id, clear the iteration counter, ptr<=grant, go to CALC.
  - No pending request: stay in IDLE, all outputs 0.
- CALC:
  - Restoring digit-by-digit square root.
  - Each cycle consumes the top 2 radicand bits and produces 1 root bit.
  - Partial remainder is RAD_W/2+2 bits; the root register fills MSB first.
  - Runs exactly RAD_W/2 cycles; on the last one, go to DONE.
- DONE:
  - resp_valid[id]=1 for exactly one cycle.
  - resp_root and resp_id are valid in this cycle and hold their values until the next DONE.
  - Next state is IDLE.
- Latency: resp_valid rises RAD_W/2+1 cycles after the req_ready cycle (13 cycles at the default).
- Throughput: at most one accept per RAD_W/2+2 cycles. No accept occurs in CALC or DONE.
- Requesters waiting while busy keep req_valid high. req_rad must be stable only in the accept cycle.
- Dropping req_valid before accept is legal; that request is never served.
- req_valid is ignored outside IDLE.
- Radicand boundaries: 0 → root 0; 2^RAD_W−1 → root 2^(RAD_W/2)−1. No overflow is possible.
- Simultaneous requests: exactly one grant, chosen by round-robin. With N=2 both requesting continuously, service strictly alternates.
- Reset in CALC or DONE aborts the operation: no resp_valid, ptr returns to N-1.
- Engine state is cleared on every accept; nothing carries over from a previous operation.

Decomposition:
- Shared package geo_pkg holds:
  - the FSM state encoding (IDLE, CALC, DONE)
  - localparam RAD_W_DEF=24
  - a helper function for the ceil-log2 used to size resp_id and the counter
- The geofence top shares this package.
- Sub-module geo_sqrt_iter:
  - ports clk, reset, start, rad, done, root
  - contains the iteration counter, remainder and root registers
- geo_sqrt_sched keeps the arbiter, pointer, id register and FSM.

Test Plan:
- Single request, req 0 with rad=1000000 → req_ready[0] for 1 cycle; 13 cycles later resp_valid[0]=1, resp_root=1000, resp_id=0.
- Boundaries: rad=0 → root 0; rad=16777215 → root 4095; rad=99 → root 9; rad=100 → root 10.
- Contention: both requesters assert in the same cycle from reset (ptr=N-1):
  - requester 0 is served first;
  - requester 1 is accepted in the cycle after resp_valid[0];
  - next simultaneous pair: requester 0 served before 1.
- Late withdrawal: req 1 asserts during CALC, then drops before IDLE → never accepted, no resp_valid[1]; scheduler returns to IDLE idle.
- Reset mid-CALC (cycle 6 of 12) → no resp_valid; outputs zero next cycle; a new request from requester 0 gets a correct result 13 cycles after acceptance.
- Random soak: 1000 random radicands on random requesters → every result equals floor(sqrt), routed to the correct id; no requester waits more than N×14 cycles while continuously requesting.
